kim_pipe_hazard_ctrl: RTL

- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Drives the enable and flush/bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves three conditions: load-use hazards, multi-cycle data-memory waits (with timeout) and taken branch/jump redirects.
- Outputs are combinational decodes of the FSM state and the current hazard inputs, so they act in the same cycle.

---
 rtl/kim_mips_pkg.sv | 13 +
 rtl/kim_haz_wait_timer.sv | 45 ++++
 rtl/kim_pipe_hazard_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/kim_mips_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline blocks.
//   MIPS_REGISTER_ADDR_WIDTH / MIPS_REGISTER_DATA_WIDTH : register-file geometry
//   RUN / MEM_WAIT / ERR                                : hazard sequencer state encoding
package kim_mips_pkg;

  localparam int unsigned MIPS_REGISTER_ADDR_WIDTH = 5;
  localparam int unsigned MIPS_REGISTER_DATA_WIDTH = 32;

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] ERR      = 2'd2;

endpackage

// File: rtl/kim_haz_wait_timer.sv
// Clearable saturating wait counter with a timeout compare.
// Ports:
//   clk_i, rst_i  clock and asynchronous active-high reset
//   clear_i       return the count to 0 (wins over inc_i)
//   inc_i         count one more wait cycle
//   expire_o      the increment being applied this cycle reaches TIMEOUT
module kim_haz_wait_timer #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic inc_i,
  output logic expire_o
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] Limit  = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

  always_comb begin
    cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CNT_W'(1);
    cnt_d   = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_inc;
    end
  end

  // Looks at the post-increment value so the caller can leave the wait state
  // on the same edge that the count reaches the limit.
  assign expire_o = inc_i & ~clear_i & (cnt_inc >= Limit);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/kim_pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline.
// Resolves, highest priority first: ERR, data-memory wait, taken branch, load-use.
// Outputs are combinational decodes of the state and the current hazard inputs.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   id_ex_* / if_id_*              load-use detection operands
//   branch_taken                   redirect resolved in EX
//   dmem_req, dmem_ready           data-memory handshake
//   pc_en .. mem_wb_bubble         pipeline register controls
//   mem_err                        sticky data-memory timeout
//   stall_cycles, flush_count      performance counters
// Optional: define KIM_HAZ_PERF_CNT_EN to build the performance counters;
// otherwise both read as constant 0 and no counter flops exist.
module kim_pipe_hazard_ctrl
  import kim_mips_pkg::*;
#(
  parameter int unsigned REG_ADDR_W   = MIPS_REGISTER_ADDR_WIDTH,
  parameter int unsigned WAIT_TIMEOUT = 255,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_ex_memtoreg,
  input  logic                  id_ex_regwrite,
  input  logic [REG_ADDR_W-1:0] id_ex_rt,
  input  logic [REG_ADDR_W-1:0] if_id_rs,
  input  logic [REG_ADDR_W-1:0] if_id_rt,
  input  logic                  branch_taken,
  input  logic                  dmem_req,
  input  logic                  dmem_ready,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  if_id_flush,
  output logic                  id_ex_en,
  output logic                  id_ex_flush,
  output logic                  ex_mem_en,
  output logic                  mem_wb_bubble,
  output logic                  mem_err,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_count
);

  logic [1:0] state_q, state_d;
  logic       mem_wait;
  logic       load_use;
  logic       tmr_clear, tmr_inc, tmr_expire;

  assign mem_wait = dmem_req & ~dmem_ready;
  assign load_use = id_ex_memtoreg & id_ex_regwrite & (id_ex_rt != '0) &
                    ((id_ex_rt == if_id_rs) | (id_ex_rt == if_id_rt));

  kim_haz_wait_timer #(
    .TIMEOUT (WAIT_TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wait_timer (
    .clk_i    (clk),
    .rst_i    (rst),
    .clear_i  (tmr_clear),
    .inc_i    (tmr_inc),
    .expire_o (tmr_expire)
  );

  // The RUN cycle that first sees the wait counts as wait cycle 1.
  always_comb begin
    state_d   = state_q;
    tmr_clear = 1'b0;
    tmr_inc   = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_wait) begin
          state_d = MEM_WAIT;
          tmr_inc = 1'b1;
        end else begin
          tmr_clear = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_d   = RUN;
          tmr_clear = 1'b1;
        end else begin
          tmr_inc = 1'b1;
          if (tmr_expire) state_d = ERR;
        end
      end
      ERR: state_d = ERR;
      default: begin
        state_d   = RUN;
        tmr_clear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_en      = 1'b1;
    id_ex_flush   = 1'b0;
    ex_mem_en     = 1'b1;
    mem_wb_bubble = 1'b0;
    if (rst) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
    end else if ((state_q == ERR) || (state_q == RUN && mem_wait) ||
                 (state_q == MEM_WAIT && !dmem_ready)) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (state_q == RUN && branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (state_q == RUN && load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
    // MEM_WAIT exit cycle keeps the all-enable default: hazards are
    // re-evaluated once back in RUN.
  end

  assign mem_err = (state_q == ERR);

`ifdef KIM_HAZ_PERF_CNT_EN
  logic [31:0] stall_q, flush_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_en)      stall_q <= stall_q + 32'd1;
      if (if_id_flush) flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule
